eth_frame_tx_ctrl: RTL

ETH_FRAME_TX_CTRL -- requirements
Module: eth_frame_tx_ctrl

---
 rtl/ethernet_header_pkg.sv | 29 ++
 rtl/eth_crc32_byte.sv | 30 +++
 rtl/eth_frame_tx_ctrl.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/ethernet_header_pkg.sv
// Shared types and constants for the Ethernet frame transmitter.
// Optional FCS support in the transmitter is selected with ETH_FCS_EN.
package ethernet_header_pkg;

  localparam int unsigned ETH_HEADER_BYTES = 14;
  localparam int unsigned ETH_FCS_BYTES    = 4;

  typedef struct packed {
    logic [5:0][7:0] mac_destination;
    logic [5:0][7:0] mac_source;
    logic [1:0][7:0] eth_type_length;
  } ethernet_header;

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    PAYLOAD,
    FCS,
    IFG
  } tx_state_e;

  // Wire order: element [0] of each field first, destination, source, type.
  function automatic logic [7:0] header_byte(input ethernet_header h, input logic [3:0] idx);
    logic [13:0][7:0] b;
    b = {h.eth_type_length, h.mac_source, h.mac_destination};
    return b[idx];
  endfunction

endpackage

// File: rtl/eth_crc32_byte.sv
// Byte-serial IEEE 802.3 CRC-32 (reflected, init all-ones, final inversion on output).
module eth_crc32_byte (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic        en_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);

  logic [31:0] crc_q, crc_d, step;

  always_comb begin
    step = crc_q;
    for (int unsigned i = 0; i < 8; i++) begin
      step = (step >> 1) ^ (((step[0] ^ data_i[i]) == 1'b1) ? 32'hEDB8_8320 : '0);
    end
    crc_d = crc_q;
    if (clr_i)     crc_d = '1;
    else if (en_i) crc_d = step;
  end

  always_ff @(posedge clk) begin
    if (rst) crc_q <= '1;
    else     crc_q <= crc_d;
  end

  assign crc_o = ~crc_q;

endmodule

// File: rtl/eth_frame_tx_ctrl.sv
// Ethernet frame transmit controller: header, payload pass-through, optional FCS, IFG.
// Define ETH_FCS_EN to append a CRC-32 frame check sequence.
module eth_frame_tx_ctrl
  import ethernet_header_pkg::*;
#(
  parameter int unsigned PACKET_PAYLOAD_BYTES = 128,
  parameter int unsigned IFG_CYCLES           = 12
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  ethernet_header header_in,
  input  logic [7:0]     pl_data,
  input  logic           pl_valid,
  output logic           pl_ready,
  output logic [7:0]     tx_data,
  output logic           tx_valid,
  input  logic           tx_ready,
  output logic           tx_last,
  output logic           busy,
  output logic           frame_done
);

  localparam logic [15:0] LAST_PL  = 16'(PACKET_PAYLOAD_BYTES - 1);
  localparam logic [15:0] LAST_HDR = 16'(ETH_HEADER_BYTES - 1);
  localparam logic [7:0]  IFG_LOAD = (IFG_CYCLES == 0) ? 8'd0 : 8'(IFG_CYCLES - 1);

  tx_state_e      state_q, state_d;
  ethernet_header hdr_q, hdr_d;
  logic [15:0]    cnt_q, cnt_d;
  logic [7:0]     ifg_q, ifg_d;
  logic           done_q, done_d;
  logic           frame_end;

`ifdef ETH_FCS_EN
  localparam logic [15:0] LAST_FCS = 16'(ETH_FCS_BYTES - 1);
  logic        crc_clr, crc_en;
  logic [31:0] crc;

  eth_crc32_byte u_crc (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (crc_clr),
    .en_i   (crc_en),
    .data_i (tx_data),
    .crc_o  (crc)
  );
`endif

  always_comb begin
    state_d   = state_q;
    hdr_d     = hdr_q;
    cnt_d     = cnt_q;
    ifg_d     = ifg_q;
    done_d    = 1'b0;
    frame_end = 1'b0;
    tx_data   = '0;
    tx_valid  = 1'b0;
    tx_last   = 1'b0;
    pl_ready  = 1'b0;
    busy      = (state_q != IDLE);
`ifdef ETH_FCS_EN
    crc_clr   = 1'b0;
    crc_en    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          hdr_d   = header_in;
          cnt_d   = '0;
          state_d = HEADER;
`ifdef ETH_FCS_EN
          crc_clr = 1'b1;
`endif
        end
      end
      HEADER: begin
        tx_valid = 1'b1;
        tx_data  = header_byte(hdr_q, cnt_q[3:0]);
        if (tx_ready) begin
`ifdef ETH_FCS_EN
          crc_en = 1'b1;
`endif
          if (cnt_q == LAST_HDR) begin
            cnt_d   = '0;
            state_d = PAYLOAD;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      PAYLOAD: begin
        tx_data  = pl_data;
        tx_valid = pl_valid;
        pl_ready = tx_ready;
`ifndef ETH_FCS_EN
        tx_last  = pl_valid && (cnt_q == LAST_PL);
`endif
        if (pl_valid && tx_ready) begin
`ifdef ETH_FCS_EN
          crc_en = 1'b1;
`endif
          if (cnt_q == LAST_PL) begin
            cnt_d = '0;
`ifdef ETH_FCS_EN
            state_d = FCS;
`else
            frame_end = 1'b1;
`endif
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
`ifdef ETH_FCS_EN
      FCS: begin
        tx_valid = 1'b1;
        tx_data  = crc[{cnt_q[1:0], 3'b000} +: 8];
        tx_last  = (cnt_q == LAST_FCS);
        if (tx_ready) begin
          if (cnt_q == LAST_FCS) begin
            cnt_d     = '0;
            frame_end = 1'b1;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
`endif
      IFG: begin
        if (ifg_q == '0) state_d = IDLE;
        else             ifg_d   = ifg_q - 8'd1;
      end
      default: state_d = IDLE;
    endcase
    // The final handshake skips IFG entirely when no gap is configured.
    if (frame_end) begin
      done_d  = 1'b1;
      ifg_d   = IFG_LOAD;
      state_d = (IFG_CYCLES == 0) ? IDLE : IFG;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      hdr_q   <= '0;
      cnt_q   <= '0;
      ifg_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hdr_q   <= hdr_d;
      cnt_q   <= cnt_d;
      ifg_q   <= ifg_d;
      done_q  <= done_d;
    end
  end

  assign frame_done = done_q;

endmodule
